// File: rtl/write_coalesce_buffer.sv
// Coalescing write buffer. Word writes are merged into DEPTH cache-line slots.
// Lines leave oldest-first as CCI write requests, with the in-flight count bounded.
module write_coalesce_buffer #(
  parameter  int ADDR_LMT    = 20,
  parameter  int MDATA       = 14,
  parameter  int CACHE_WIDTH = 512,
  parameter  int DATA_WIDTH  = 32,
  parameter  int DEPTH       = 4,
  parameter  int MAX_OUTST   = 16,
  localparam int WORDS       = CACHE_WIDTH / DATA_WIDTH,
  localparam int WIDX        = $clog2(WORDS),
  localparam int OW          = $clog2(MAX_OUTST) + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_LMT+WIDX-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_now,
  output logic                     wr_ready,
  output logic                     wr_valid,
  output logic [ADDR_LMT-1:0]      wr_req_addr,
  output logic [MDATA-1:0]         wr_req_mdata,
  output logic [CACHE_WIDTH-1:0]   wr_req_data,
  output logic                     wr_req_en,
  input  logic                     wr_req_almostfull,
  input  logic                     wr_rsp0_valid,
  input  logic [MDATA-1:0]         wr_rsp0_mdata,
  input  logic                     wr_rsp1_valid,
  input  logic [MDATA-1:0]         wr_rsp1_mdata,
  output logic [OW-1:0]            outstanding
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   SLOTS   = (PW+1)'(DEPTH);
  localparam logic [OW-1:0] OUT_LMT = OW'(MAX_OUTST);

  function automatic logic tag_parity(input logic [MDATA-1:0] tag);
    return ^tag;
  endfunction

  // Slot storage: an age-ordered ring, head is the oldest line
  logic [DEPTH-1:0]       slot_valid_r;
  logic [ADDR_LMT-1:0]    slot_addr_r [DEPTH];
  logic [CACHE_WIDTH-1:0] slot_data_r [DEPTH];
  logic [WORDS-1:0]       slot_wv_r   [DEPTH];
  logic [PW-1:0]          head_r;
  logic [PW-1:0]          tail_r;
  logic [PW:0]            count_r;

  logic                   flush_pend_r;
  logic [MDATA-1:0]       mdata_r;
  logic [OW-1:0]          outst_r;
  logic                   wr_req_en_r;
  logic [ADDR_LMT-1:0]    wr_req_addr_r;
  logic [MDATA-1:0]       wr_req_mdata_r;
  logic [CACHE_WIDTH-1:0] wr_req_data_r;
  logic                   wr_valid_r;

  logic [ADDR_LMT-1:0]    line_s;
  logic [WIDX-1:0]        widx_s;
  logic                   full_s;
  logic                   ready_s;
  logic                   issue_s;
  logic [DEPTH-1:0]       match_s;
  logic                   hit_s;
  logic [PW-1:0]          hit_idx_s;
  logic                   accept_s;
  logic                   alloc_s;
  logic                   drain_s;
  logic [CACHE_WIDTH-1:0] head_line_s;
  logic [1:0]             rsp_cnt_s;
  logic [OW-1:0]          out_dec_s;
  logic [OW-1:0]          out_next_s;
  logic                   unused_tag_parity_s;

  assign line_s              = wr_addr[ADDR_LMT+WIDX-1:WIDX];
  assign widx_s              = wr_addr[WIDX-1:0];
  assign full_s              = (count_r == SLOTS);
  assign ready_s             = ~full_s & ~flush_pend_r;
  assign accept_s            = wr_en & ready_s;
  assign alloc_s             = accept_s & ~hit_s;
  assign drain_s             = flush_pend_r & (count_r == '0) & (outst_r == '0);
  assign unused_tag_parity_s = tag_parity(wr_rsp0_mdata) ^ tag_parity(wr_rsp1_mdata);

  // Head issue decision, evaluated on the slot state after the last edge
  always_comb begin
    issue_s = 1'b0;
    if (slot_valid_r[head_r] && ((&slot_wv_r[head_r]) || flush_pend_r || full_s) &&
        !wr_req_almostfull && (outst_r < OUT_LMT)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Address match; the head leaving this cycle cannot absorb a write
  always_comb begin
    match_s   = '0;
    hit_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = slot_valid_r[i] && (slot_addr_r[i] == line_s) &&
                   !(issue_s && (head_r == PW'(i)));
      hit_idx_s  = match_s[i] ? PW'(i) : hit_idx_s;
    end
    hit_s = |match_s;
  end

  // Head line with unwritten words forced to zero
  always_comb begin
    head_line_s = '0;
    for (int w = 0; w < WORDS; w++) begin
      head_line_s[w*DATA_WIDTH +: DATA_WIDTH] = slot_wv_r[head_r][w] ?
          slot_data_r[head_r][w*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  // Outstanding count: responses saturate at zero before the new issue is added
  always_comb begin
    rsp_cnt_s = {1'b0, wr_rsp0_valid} + {1'b0, wr_rsp1_valid};
    out_dec_s = '0;
    if (outst_r > OW'(rsp_cnt_s)) begin
      out_dec_s = outst_r - OW'(rsp_cnt_s);
    end else begin
      out_dec_s = '0;
    end
    out_next_s = out_dec_s + OW'(issue_s);
  end

  // Slot ring update: free the issued head, merge or allocate the accepted word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_r <= '0;
      head_r       <= '0;
      tail_r       <= '0;
      count_r      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_addr_r[i] <= '0;
        slot_data_r[i] <= '0;
        slot_wv_r[i]   <= '0;
      end
    end else begin
      if (issue_s) begin
        slot_valid_r[head_r] <= 1'b0;
        slot_wv_r[head_r]    <= '0;
        head_r               <= head_r + PW'(1);
      end
      if (accept_s && hit_s) begin
        slot_data_r[hit_idx_s][widx_s*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
        slot_wv_r[hit_idx_s][widx_s]                           <= 1'b1;
      end else if (alloc_s) begin
        slot_valid_r[tail_r]                                 <= 1'b1;
        slot_addr_r[tail_r]                                  <= line_s;
        slot_wv_r[tail_r]                                    <= {{(WORDS-1){1'b0}}, 1'b1} << widx_s;
        slot_data_r[tail_r][widx_s*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
        tail_r                                               <= tail_r + PW'(1);
      end
      case ({alloc_s, issue_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Request registers, tag sequence and in-flight count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_req_en_r    <= 1'b0;
      wr_req_addr_r  <= '0;
      wr_req_mdata_r <= '0;
      wr_req_data_r  <= '0;
      mdata_r        <= '0;
      outst_r        <= '0;
    end else begin
      wr_req_en_r <= issue_s;
      outst_r     <= out_next_s;
      if (issue_s) begin
        wr_req_addr_r  <= slot_addr_r[head_r];
        wr_req_data_r  <= head_line_s;
        wr_req_mdata_r <= mdata_r;
        mdata_r        <= mdata_r + MDATA'(1);
      end
    end
  end

  // Flush tracking and completion pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pend_r <= 1'b0;
      wr_valid_r   <= 1'b0;
    end else begin
      wr_valid_r <= drain_s;
      if (drain_s) begin
        flush_pend_r <= 1'b0;
      end else if (wr_now) begin
        flush_pend_r <= 1'b1;
      end
    end
  end

  assign wr_ready     = ready_s;
  assign wr_valid     = wr_valid_r;
  assign wr_req_en    = wr_req_en_r;
  assign wr_req_addr  = wr_req_addr_r;
  assign wr_req_mdata = wr_req_mdata_r;
  assign wr_req_data  = wr_req_data_r;
  assign outstanding  = outst_r;

endmodule

// File: tb/tb_write_coalesce_buffer.sv
// Bench for write_coalesce_buffer: randomized and directed stimulus checked by a
// queue-based line model; a monitor pops expected requests as the DUT issues them.
module tb_write_coalesce_buffer;

  localparam int AW = 20, MD = 14, CW = 512, DW = 32, DEPTH = 4, MAXO = 4;
  localparam int WORDS = CW / DW, WIDX = $clog2(WORDS), OW = $clog2(MAXO) + 1;

  logic clk = 1'b0, reset_n = 1'b0, wr_en = 1'b0, wr_now = 1'b0;
  logic wr_req_almostfull = 1'b0, wr_rsp0_valid = 1'b0, wr_rsp1_valid = 1'b0;
  logic [AW+WIDX-1:0] wr_addr = '0;
  logic [DW-1:0]      wr_data = '0;
  logic [MD-1:0]      wr_rsp0_mdata = '0, wr_rsp1_mdata = '0;
  logic               wr_ready, wr_valid, wr_req_en;
  logic [AW-1:0]      wr_req_addr;
  logic [MD-1:0]      wr_req_mdata;
  logic [CW-1:0]      wr_req_data;
  logic [OW-1:0]      outstanding;

  write_coalesce_buffer #(.ADDR_LMT(AW), .MDATA(MD), .CACHE_WIDTH(CW), .DATA_WIDTH(DW),
                          .DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_now(wr_now), .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_req_addr(wr_req_addr),
    .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data), .wr_req_en(wr_req_en),
    .wr_req_almostfull(wr_req_almostfull), .wr_rsp0_valid(wr_rsp0_valid),
    .wr_rsp0_mdata(wr_rsp0_mdata), .wr_rsp1_valid(wr_rsp1_valid),
    .wr_rsp1_mdata(wr_rsp1_mdata), .outstanding(outstanding));

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [CW-1:0]    data;
    logic [WORDS-1:0] mask;
  } line_t;

  typedef struct packed {
    int            cyc;
    logic [AW-1:0] addr;
    logic [MD-1:0] mdata;
    logic [CW-1:0] data;
  } req_t;

  line_t lines[$];
  req_t  expq[$];
  int    m_cyc = 0, m_out = 0;
  bit    m_fpend = 1'b0, exp_valid = 1'b0, exp_ready = 1'b1;
  logic [MD-1:0] m_mdata = '0;
  int    n_checks = 0, n_errors = 0;
  bit    rsp_on = 1'b1, rsp_force = 1'b0, af_rand = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: lines kept oldest-first, updated on every clock edge
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      lines.delete(); expq.delete();
      m_out = 0; m_fpend = 1'b0; m_mdata = '0; exp_valid = 1'b0; exp_ready = 1'b1;
    end else begin
      int    n, dec;
      bit    rdy, iss, drain, found;
      line_t hd, tmp;
      logic [AW-1:0]   la;
      logic [WIDX-1:0] wi;
      m_cyc++;
      n     = lines.size();
      rdy   = (n < DEPTH) && !m_fpend;
      iss   = (n > 0) && ((&lines[0].mask) || m_fpend || n == DEPTH) &&
              !wr_req_almostfull && (m_out < MAXO);
      drain = m_fpend && (n == 0) && (m_out == 0);
      if (iss) begin
        hd = lines.pop_front();
        expq.push_back('{cyc: m_cyc, addr: hd.addr, mdata: m_mdata, data: hd.data});
        m_mdata = m_mdata + 1'b1;
      end
      if (wr_en && rdy) begin
        la = wr_addr[AW+WIDX-1:WIDX];
        wi = wr_addr[WIDX-1:0];
        found = 1'b0;
        for (int i = 0; i < lines.size(); i++) begin
          if (!found && lines[i].addr == la) begin
            tmp = lines[i];
            tmp.data[wi*DW +: DW] = wr_data;
            tmp.mask[wi] = 1'b1;
            lines[i] = tmp;
            found = 1'b1;
          end
        end
        if (!found) begin
          tmp = '0;
          tmp.addr = la;
          tmp.data[wi*DW +: DW] = wr_data;
          tmp.mask[wi] = 1'b1;
          lines.push_back(tmp);
        end
      end
      dec   = int'(wr_rsp0_valid) + int'(wr_rsp1_valid);
      m_out = ((m_out > dec) ? m_out - dec : 0) + int'(iss);
      exp_valid = drain;
      if (drain) m_fpend = 1'b0;
      else if (wr_now) m_fpend = 1'b1;
      exp_ready = (lines.size() < DEPTH) && !m_fpend;
    end
  end

  // Monitor: compares issued requests and per-cycle status against the model
  initial forever begin
    req_t e;
    @(negedge clk);
    while (expq.size() > 0 && expq[0].cyc < m_cyc) begin
      n_checks++; n_errors++;
      $display("FAIL missing_req: no wr_req_en for line %0h expected in cycle %0d",
               expq[0].addr, expq[0].cyc);
      void'(expq.pop_front());
    end
    if (wr_req_en === 1'b1) begin
      if (expq.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_req: wr_req_en for line %0h in cycle %0d", wr_req_addr, m_cyc);
      end else begin
        e = expq.pop_front();
        chk("req_cycle", m_cyc, e.cyc);
        chk("req_addr", wr_req_addr, e.addr);
        chk("req_mdata", wr_req_mdata, e.mdata);
        n_checks++;
        if (wr_req_data !== e.data) begin
          n_errors++;
          $display("FAIL req_data: got %h expected %h", wr_req_data, e.data);
        end
      end
    end
    chk("wr_ready", wr_ready, exp_ready);
    chk("wr_valid", wr_valid, exp_valid);
    chk("outstanding", outstanding, m_out);
  end

  // One clock step; responses never exceed the model's in-flight count unless forced
  task automatic tick();
    int avail;
    avail = m_out;
    wr_rsp0_valid = 1'b0;
    wr_rsp1_valid = 1'b0;
    wr_rsp0_mdata = MD'($urandom);
    wr_rsp1_mdata = MD'($urandom);
    if (rsp_force) begin
      wr_rsp0_valid = 1'b1;
      wr_rsp1_valid = 1'b1;
    end else if (rsp_on) begin
      if (avail > 0 && $urandom_range(0, 2) == 0) begin wr_rsp0_valid = 1'b1; avail--; end
      if (avail > 0 && $urandom_range(0, 2) == 0) wr_rsp1_valid = 1'b1;
    end
    if (af_rand) wr_req_almostfull = ($urandom_range(0, 3) == 0);
    @(posedge clk);
    #2;
    wr_now = 1'b0;
  endtask

  task automatic write_word(input logic [AW-1:0] la, input logic [WIDX-1:0] wi,
                            input logic [DW-1:0] d);
    bit r, done;
    done = 1'b0;
    wr_en = 1'b1; wr_addr = {la, wi}; wr_data = d;
    for (int i = 0; i < 400 && !done; i++) begin
      r = exp_ready;
      tick();
      done = r;
    end
    wr_en = 1'b0;
    if (!done) chk("write_accept_timeout", 0, 1);
  endtask

  task automatic write_line(input logic [AW-1:0] la);
    for (int w = 0; w < WORDS; w++) write_word(la, WIDX'(w), DW'($urandom));
  endtask

  task automatic flush_wait(input string nm);
    bit seen;
    seen = 1'b0;
    wr_now = 1'b1;
    for (int i = 0; i < 800 && !seen; i++) begin
      tick();
      if (wr_valid) seen = 1'b1;
    end
    chk({nm, "_flush_done"}, seen, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    chk("rst_req_addr", wr_req_addr, 0);
    chk("rst_req_mdata", wr_req_mdata, 0);
    chk("rst_req_data_zero", (wr_req_data == '0), 1);
    chk("rst_req_en", wr_req_en, 0);

    // Full sequential line
    for (int w = 0; w < WORDS; w++) write_word(20'h00010, WIDX'(w), DW'($urandom));
    flush_wait("full_line");

    // Partial line flushed on request
    write_word(20'h00005, 4'd0, DW'($urandom));
    write_word(20'h00005, 4'd1, DW'($urandom));
    write_word(20'h00005, 4'd15, DW'($urandom));
    flush_wait("partial_line");

    // Five distinct lines force the oldest out when all slots are taken
    for (int k = 0; k < 5; k++) write_word(AW'(32'h100 + k), WIDX'(k), DW'($urandom));
    flush_wait("five_lines");

    // Downstream backpressure holds two full lines
    wr_req_almostfull = 1'b1;
    write_line(20'h00200);
    write_line(20'h00201);
    repeat (20) tick();
    wr_req_almostfull = 1'b0;
    flush_wait("almostfull");

    // In-flight limit, then two responses in one cycle
    rsp_on = 1'b0;
    for (int k = 0; k < 6; k++) write_line(AW'(32'h300 + k));
    repeat (5) tick();
    chk("outst_cap", outstanding, MAXO);
    rsp_force = 1'b1;
    tick();
    rsp_force = 1'b0;
    repeat (4) tick();
    rsp_on = 1'b1;
    flush_wait("outst_limit");

    // Randomized traffic over a small line pool
    af_rand = 1'b1;
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 59) == 0) wr_now = 1'b1;
      if ($urandom_range(0, 2) != 0)
        write_word(AW'(32'h400 + $urandom_range(0, 2)), WIDX'($urandom_range(0, WORDS - 1)),
                   DW'($urandom));
      else
        tick();
    end
    af_rand = 1'b0;
    wr_req_almostfull = 1'b0;
    flush_wait("random");

    // Reset with lines in flight, then stray responses
    rsp_on = 1'b0;
    for (int k = 0; k < 3; k++) write_line(AW'(32'h500 + k));
    write_word(20'h00503, 4'd2, DW'($urandom));
    write_word(20'h00503, 4'd7, DW'($urandom));
    repeat (3) tick();
    chk("pre_reset_outst", outstanding, 3);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    rsp_force = 1'b1;
    tick();
    rsp_force = 1'b0;
    tick();
    chk("post_reset_outst", outstanding, 0);
    chk("post_reset_ready", wr_ready, 1);
    chk("post_reset_req_en", wr_req_en, 0);

    // Flush of an empty buffer completes two cycles after the request
    rsp_on = 1'b1;
    wr_now = 1'b1;
    tick();
    chk("empty_flush_c1", wr_valid, 0);
    tick();
    chk("empty_flush_c2", wr_valid, 1);
    repeat (3) tick();
    chk("expq_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/write_coalesce_buffer.md
# write_coalesce_buffer

Parametrised successor to the single-line write buffer that sits between a compute kernel (e.g. matrix_multiply) and the CCI write channel. Accepts DATA_WIDTH-bit word writes, coalesces them in DEPTH cache-line slots, and issues full or partial lines as CACHE_WIDTH-bit write requests. Bounds in-flight writes, counts write responses, and signals completion of a flush. Unlike the single-line buffer, it adds multi-line merging, upstream backpressure and an outstanding-write limit.

## Interface
- ADDR_LMT, 20, cache-line address width
- MDATA, 14, request/response tag width
- CACHE_WIDTH, 512, line width in bits
- DATA_WIDTH, 32, upstream word width; WORDS = CACHE_WIDTH/DATA_WIDTH (power of 2), WIDX = log2(WORDS)
- DEPTH, 4, number of line slots (power of 2, ≥2)
- MAX_OUTST, 16, maximum un-acknowledged line writes

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  word write strobe, accepted when wr_ready=1
- wr_addr  in  ADDR_LMT+WIDX  word address: {line address, word index}
- wr_data  in  DATA_WIDTH  word data
- wr_now  in  1  flush request pulse
- wr_ready  out  1  word can be accepted this cycle
- wr_valid  out  1  one-cycle pulse: flush complete, all lines acknowledged
- wr_req_addr  out  ADDR_LMT  line address of the issued request
- wr_req_mdata  out  MDATA  request tag: a sequence counter, +1 per request, wraps
- wr_req_data  out  CACHE_WIDTH  line data; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_req_en  out  1  one-cycle request strobe
- wr_req_almostfull  in  1  downstream full; no issue while high
- wr_rsp0_valid / wr_rsp1_valid  in  1  write acknowledge, one line each
- wr_rsp0_mdata / wr_rsp1_mdata  in  MDATA  tag (not checked)
- outstanding  out  log2(MAX_OUTST)+1  lines issued but not acknowledged

## Operation
- Slot state: valid bit, line address, WORDS data words, WORDS word-valid bits. Slots form an age-ordered FIFO with head = oldest.
- Accept when wr_en & wr_ready. A line-address match on any valid slot other than the slot issuing this cycle merges the word into that slot. A later write to the same word overwrites the earlier one. On a miss, the word goes to a newly allocated slot at the tail.
- wr_ready = (occupied slots < DEPTH) & ~flush_pend. This is conservative: ready is independent of hit or miss.
- Head issue condition: head valid & (all word-valid bits set | flush_pend | occupancy==DEPTH) & ~wr_req_almostfull & outstanding < MAX_OUTST.
- Only the head is issued, so lines leave in allocation order. Non-head full lines wait for the head.
- Unwritten words of a partial line are sent as zero.
- On issue the head slot is freed and the mdata counter increments.
- outstanding: +1 on wr_req_en. -1 per asserted rsp0 and rsp1, so it can drop by 2 in one cycle. It saturates at 0, and responses with outstanding==0 are ignored.
- Flush: wr_now sets flush_pend. wr_en and wr_now in the same cycle: the word is accepted and is included in the flush. When flush_pend is set, all slots are empty and outstanding==0, wr_valid pulses one cycle and flush_pend clears. wr_now while flush_pend is already set has no extra effect.

## Timing
- Reset (async assert, sync release): all slots invalid, counters 0, flush_pend 0. Reset values: wr_req_en=0, wr_req_addr=0, wr_req_mdata=0, wr_req_data=0, wr_valid=0, outstanding=0, wr_ready=1.
- Reset mid-operation discards all slots and in-flight counts. Responses arriving after reset are absorbed by the saturation rule.
- Word accepted at edge k updates its slot at k.
- Issue decision is combinational on slot state after edge k. wr_req_* are registered at edge k+1, giving one cycle from line-full to wr_req_en.
- Back-to-back issue is permitted every cycle.
- wr_req_almostfull sampled high at edge k blocks issue at edge k.
- A hit on the issuing head at its issue edge is not merged: it allocates a new slot.
- wr_valid is registered and asserts on the edge after the drain condition holds. wr_now with an empty buffer and outstanding==0 gives wr_valid 2 cycles after wr_now.

## Test plan
- 16 sequential words to line 0x00010 with rsp after 3 cycles -> one wr_req_en, addr 0x00010, data words 0..15 match, mdata 0; outstanding goes 1 then 0.
- 3 words to line 0x5 (idx 0,1,15), then wr_now -> one request with only those words nonzero; wr_ready=0 until wr_valid; wr_valid pulses after the response.
- Misses to 5 distinct lines (DEPTH=4) -> wr_ready drops with 4 slots occupied; head issued; lines emitted in allocation order.
- Hold almostfull high for 20 cycles with 2 full lines pending -> no wr_req_en; after release, two consecutive-cycle requests with mdata 0,1.
- MAX_OUTST=2, 4 full lines, no responses -> exactly 2 requests. Then rsp0 and rsp1 in the same cycle -> outstanding 2->0 and 2 more issue.
- Assert reset_n low mid-fill with outstanding=3; after release send 2 stray rsps -> outstanding stays 0, wr_ready=1, wr_req_en=0.
